// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C line conditioner.
package i2c_pkg;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StActive = 1'b1
    } i2c_state_e;

    // 8 data bits plus the ACK slot
    localparam int unsigned FRAME_BITS       = 9;
    localparam int unsigned BIT_CNT_W        = 4;
    localparam int unsigned DEFAULT_FILT_LEN = 3;
    localparam int unsigned DEFAULT_TOUT_CYC = 4096;

    // Advance the in-frame bit index, wrapping after the ACK slot
    function automatic logic [BIT_CNT_W-1:0] next_bit_cnt(input logic [BIT_CNT_W-1:0] cnt);
        if (cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
            return '0;
        end
        return cnt + BIT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter for one open-drain line.
// The filtered output only follows the synchronised input after FILT_LEN consecutive
// disagreeing samples; both stages preset to 1 (idle bus level).
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int unsigned FILT_LEN = DEFAULT_FILT_LEN
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic line_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic       filt_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Synchroniser chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
        end
    end

    // Count disagreeing samples; any agreeing sample restarts the run
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == 4'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Filter state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/i2c_line_conditioner.sv
// I2C slave front end: filters SCL/SDA, detects START/STOP/repeated START, captures data
// bits on SCL rising edges and tracks the bit index within the 9-bit frame.
// Optional SCL-low bus timeout is compiled in when I2C_TIMEOUT_EN is defined.
module i2c_line_conditioner
    import i2c_pkg::*;
#(
    parameter int unsigned FILT_LEN = DEFAULT_FILT_LEN,
    parameter int unsigned TOUT_CYC = DEFAULT_TOUT_CYC
) (
    input  logic                 CLK,
    input  logic                 RSTbar,
    input  logic                 SCL_in,
    input  logic                 SDA_in,
    output logic                 SCL,
    output logic                 din,
    output logic                 START,
    output logic                 STOP,
    output logic                 RSTART,
    output logic                 BitValid,
    output logic [BIT_CNT_W-1:0] BitCnt,
    output logic                 BusBusy
`ifdef I2C_TIMEOUT_EN
    ,
    output logic                 Timeout
`endif
);

    logic                 scl_f;
    logic                 sda_f;
    logic                 sclq_q;
    logic                 sdaq_q;
    logic                 scl_rise;
    logic                 sda_fall;
    logic                 sda_rise;
    logic                 start_cond;
    logic                 stop_cond;
    logic                 tout_hit;

    i2c_state_e           state_q;
    i2c_state_e           state_d;
    logic                 din_q;
    logic                 din_d;
    logic [BIT_CNT_W-1:0] cnt_q;
    logic [BIT_CNT_W-1:0] cnt_d;
    logic                 first_q;
    logic                 first_d;
    logic                 stop_q;
    logic                 stop_d;
    logic                 rstart_q;
    logic                 rstart_d;
    logic                 bv_q;
    logic                 bv_d;

    i2c_glitch_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_scl_filter (
        .clk_i  (CLK),
        .rst_ni (RSTbar),
        .line_i (SCL_in),
        .line_o (scl_f)
    );

    i2c_glitch_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_sda_filter (
        .clk_i  (CLK),
        .rst_ni (RSTbar),
        .line_i (SDA_in),
        .line_o (sda_f)
    );

    // Previous filtered line levels for edge detection
    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            sclq_q <= 1'b1;
            sdaq_q <= 1'b1;
        end else begin
            sclq_q <= scl_f;
            sdaq_q <= sda_f;
        end
    end

    // SDA edges only count as bus conditions while SCL is stable high; an SDA edge that
    // coincides with an SCL edge is treated as a data change.
    assign scl_rise   = scl_f & ~sclq_q;
    assign sda_fall   = sdaq_q & ~sda_f;
    assign sda_rise   = ~sdaq_q & sda_f;
    assign start_cond = sda_fall & sclq_q & scl_f;
    assign stop_cond  = sda_rise & sclq_q & scl_f;

`ifdef I2C_TIMEOUT_EN
    localparam int unsigned ToutW = (TOUT_CYC > 1) ? $clog2(TOUT_CYC) : 1;

    logic [ToutW-1:0] tout_q;
    logic [ToutW-1:0] tout_d;
    logic             tout_pulse_q;

    assign tout_hit = (state_q == StActive) && !scl_f && (tout_q == ToutW'(TOUT_CYC - 1));

    // Count CLKs of SCL low while a transfer is in progress
    always_comb begin
        tout_d = '0;
        if ((state_q == StActive) && !scl_f && !tout_hit) begin
            tout_d = tout_q + ToutW'(1);
        end
    end

    // Timeout counter and its output pulse
    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            tout_q       <= '0;
            tout_pulse_q <= 1'b0;
        end else begin
            tout_q       <= tout_d;
            tout_pulse_q <= tout_hit;
        end
    end

    assign Timeout = tout_pulse_q;
`else
    assign tout_hit = 1'b0;
`endif

    // Bus FSM, data capture and bit counter next state
    always_comb begin
        state_d  = state_q;
        din_d    = din_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        stop_d   = 1'b0;
        rstart_d = 1'b0;
        bv_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_cond) begin
                    state_d = StActive;
                    cnt_d   = '0;
                    first_d = 1'b1;
                end
            end
            StActive: begin
                if (tout_hit) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    first_d = 1'b0;
                end else if (start_cond) begin
                    rstart_d = 1'b1;
                    cnt_d    = '0;
                    first_d  = 1'b1;
                end else if (stop_cond) begin
                    state_d = StIdle;
                    stop_d  = 1'b1;
                    cnt_d   = '0;
                    first_d = 1'b0;
                end else if (scl_rise) begin
                    din_d = sda_f;
                    bv_d  = 1'b1;
                    // First bit after (re)START is index 0; later bits advance
                    if (first_q) begin
                        cnt_d   = '0;
                        first_d = 1'b0;
                    end else begin
                        cnt_d = next_bit_cnt(cnt_q);
                    end
                end
            end
        endcase
    end

    // FSM and registered outputs
    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            state_q  <= StIdle;
            din_q    <= 1'b1;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            stop_q   <= 1'b0;
            rstart_q <= 1'b0;
            bv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            stop_q   <= stop_d;
            rstart_q <= rstart_d;
            bv_q     <= bv_d;
        end
    end

    assign SCL      = scl_f;
    assign din      = din_q;
    assign START    = (state_q == StActive);
    assign BusBusy  = (state_q == StActive);
    assign STOP     = stop_q;
    assign RSTART   = rstart_q;
    assign BitValid = bv_q;
    assign BitCnt   = cnt_q;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Directed bench for i2c_line_conditioner (FILT_LEN=3, TOUT_CYC=64, 10 ns clock).
module tb_i2c_line_conditioner;

    logic       CLK = 1'b0;
    logic       RSTbar;
    logic       SCL_in;
    logic       SDA_in;
    logic       SCL;
    logic       din;
    logic       START;
    logic       STOP;
    logic       RSTART;
    logic       BitValid;
    logic [3:0] BitCnt;
    logic       BusBusy;
`ifdef I2C_TIMEOUT_EN
    logic       Timeout;
    localparam bit ToutOn = 1'b1;
`else
    localparam bit ToutOn = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic scl;
        logic sda;
        int   cyc;
        int   e_scl;
        int   e_din;
        int   e_start;
        int   e_cnt;
        int   e_bv;
        int   e_stop;
        int   e_rst;
        int   e_tout;
    } vec_t;

    vec_t vecs[$];

    i2c_line_conditioner #(
        .FILT_LEN (3),
        .TOUT_CYC (64)
    ) dut (
        .CLK      (CLK),
        .RSTbar   (RSTbar),
        .SCL_in   (SCL_in),
        .SDA_in   (SDA_in),
        .SCL      (SCL),
        .din      (din),
        .START    (START),
        .STOP     (STOP),
        .RSTART   (RSTART),
        .BitValid (BitValid),
        .BitCnt   (BitCnt),
        .BusBusy  (BusBusy)
`ifdef I2C_TIMEOUT_EN
        ,
        .Timeout  (Timeout)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic void chk(input string name, input int idx, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s step %0d: got %0d want %0d", name, idx, act, exp_v);
        end
    endfunction

    function automatic void add(input logic scl, input logic sda, input int cyc,
                                input int e_scl, input int e_din, input int e_start,
                                input int e_cnt, input int e_bv, input int e_stop,
                                input int e_rst, input int e_tout);
        vec_t v;
        v.scl = scl; v.sda = sda; v.cyc = cyc;
        v.e_scl = e_scl; v.e_din = e_din; v.e_start = e_start; v.e_cnt = e_cnt;
        v.e_bv = e_bv; v.e_stop = e_stop; v.e_rst = e_rst; v.e_tout = e_tout;
        vecs.push_back(v);
    endfunction

    // Drive pins, hold for v.cyc clocks counting pulse-high cycles, then compare
    task automatic run_step(input int idx, input vec_t v);
        int n_bv;
        int n_stop;
        int n_rst;
        int n_tout;
        n_bv = 0; n_stop = 0; n_rst = 0; n_tout = 0;
        SCL_in = v.scl;
        SDA_in = v.sda;
        repeat (v.cyc) begin
            @(posedge CLK);
            #1;
            n_bv   += int'(BitValid);
            n_stop += int'(STOP);
            n_rst  += int'(RSTART);
`ifdef I2C_TIMEOUT_EN
            n_tout += int'(Timeout);
`endif
        end
        chk("scl", idx, int'(SCL), v.e_scl);
        chk("din", idx, int'(din), v.e_din);
        chk("start", idx, int'(START), v.e_start);
        chk("busbusy", idx, int'(BusBusy), v.e_start);
        chk("bitcnt", idx, int'(BitCnt), v.e_cnt);
        chk("bitvalid_cnt", idx, n_bv, v.e_bv);
        chk("stop_cnt", idx, n_stop, v.e_stop);
        chk("rstart_cnt", idx, n_rst, v.e_rst);
`ifdef I2C_TIMEOUT_EN
        chk("timeout_cnt", idx, n_tout, v.e_tout);
`endif
    endtask

    initial begin
        logic [7:0] byte_v;
        int         din_prev;
        int         cnt_prev;
        int         b;
        int         lat;
        bit         found;
        vec_t       hv;

        // Idle, START, byte 0xA0 + ACK 0
        add(1, 1, 50, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 10, 1, 1, 1, 0, 0, 0, 0, 0);
        byte_v   = 8'hA0;
        din_prev = 1;
        cnt_prev = 0;
        for (int i = 0; i < 9; i++) begin
            b = (i < 8) ? int'(byte_v[7-i]) : 0;
            add(0, b[0], 10, 0, din_prev, 1, cnt_prev, 0, 0, 0, 0);
            add(1, b[0], 10, 1, b, 1, i, 1, 0, 0, 0);
            din_prev = b;
            cnt_prev = i;
        end
        // 2-CLK SDA spike with SCL high: filtered out
        add(1, 1, 2, 1, 0, 1, 8, 0, 0, 0, 0);
        add(1, 0, 10, 1, 0, 1, 8, 0, 0, 0, 0);
        // Clock with SDA high (wraps 8->0), repeated START, two bits, STOP
        add(0, 0, 10, 0, 0, 1, 8, 0, 0, 0, 0);
        add(0, 1, 10, 0, 0, 1, 8, 0, 0, 0, 0);
        add(1, 1, 10, 1, 1, 1, 0, 1, 0, 0, 0);
        add(1, 0, 10, 1, 1, 1, 0, 0, 0, 1, 0);
        add(0, 1, 10, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 10, 1, 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 10, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 10, 1, 0, 1, 1, 1, 0, 0, 0);
        add(1, 1, 10, 1, 0, 0, 0, 0, 1, 0, 0);
        // IDLE: clock edges and STOP condition are ignored
        add(0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            add(0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
            add(1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        end
        // START, two bits, then SCL held low
        add(1, 0, 10, 1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 10, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 10, 1, 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 10, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 10, 1, 0, 1, 1, 1, 0, 0, 0);
        if (ToutOn) begin
            add(0, 1, 72, 0, 0, 0, 0, 0, 0, 0, 1);
            add(1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
            add(0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0);
            add(1, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0);
            add(1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        end else begin
            add(0, 1, 72, 0, 0, 1, 1, 0, 0, 0, 0);
            add(1, 1, 10, 1, 1, 1, 2, 1, 0, 0, 0);
            add(0, 0, 10, 0, 1, 1, 2, 0, 0, 0, 0);
            add(1, 0, 10, 1, 0, 1, 3, 1, 0, 0, 0);
            add(1, 1, 10, 1, 0, 0, 0, 0, 1, 0, 0);
        end

        // Reset values
        RSTbar = 1'b0;
        SCL_in = 1'b1;
        SDA_in = 1'b1;
        #12;
        chk("rst_scl", -1, int'(SCL), 1);
        chk("rst_din", -1, int'(din), 1);
        chk("rst_start", -1, int'(START), 0);
        chk("rst_bitcnt", -1, int'(BitCnt), 0);
        chk("rst_pulses", -1, int'(STOP) + int'(RSTART) + int'(BitValid), 0);
        @(posedge CLK);
        #1;
        RSTbar = 1'b1;

        foreach (vecs[i]) begin
            run_step(i, vecs[i]);
        end

        // START latency: SDA pin fall to START high
        SDA_in = 1'b0;
        lat    = 0;
        found  = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(posedge CLK);
            #1;
            if (START) begin
                lat   = k;
                found = 1'b1;
            end
        end
        chk("start_latency", 100, lat, 6);
        repeat (4) @(posedge CLK);
        #1;

        // One bit, then reset while SCL is low mid-byte
        hv = '{scl: 1'b0, sda: 1'b1, cyc: 10, e_scl: 0, e_din: 0, e_start: 1, e_cnt: 0,
               e_bv: 0, e_stop: 0, e_rst: 0, e_tout: 0};
        run_step(101, hv);
        hv = '{scl: 1'b1, sda: 1'b1, cyc: 10, e_scl: 1, e_din: 1, e_start: 1, e_cnt: 0,
               e_bv: 1, e_stop: 0, e_rst: 0, e_tout: 0};
        run_step(102, hv);
        hv = '{scl: 1'b0, sda: 1'b0, cyc: 10, e_scl: 0, e_din: 1, e_start: 1, e_cnt: 0,
               e_bv: 0, e_stop: 0, e_rst: 0, e_tout: 0};
        run_step(103, hv);
        #2;
        RSTbar = 1'b0;
        #1;
        chk("midrst_scl", 104, int'(SCL), 1);
        chk("midrst_din", 104, int'(din), 1);
        chk("midrst_start", 104, int'(START), 0);
        chk("midrst_busbusy", 104, int'(BusBusy), 0);
        chk("midrst_bitcnt", 104, int'(BitCnt), 0);
        repeat (3) @(posedge CLK);
        #1;
        SCL_in = 1'b1;
        SDA_in = 1'b1;
        RSTbar = 1'b1;

        // After reset a clock edge needs a fresh START before it counts
        hv = '{scl: 1'b0, sda: 1'b1, cyc: 10, e_scl: 0, e_din: 1, e_start: 0, e_cnt: 0,
               e_bv: 0, e_stop: 0, e_rst: 0, e_tout: 0};
        run_step(105, hv);
        hv = '{scl: 1'b1, sda: 1'b1, cyc: 10, e_scl: 1, e_din: 1, e_start: 0, e_cnt: 0,
               e_bv: 0, e_stop: 0, e_rst: 0, e_tout: 0};
        run_step(106, hv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
